// File: rtl/rr_sel_pkg.sv
// Shared types and index helpers for the rr_sel round-robin selector.
package rr_sel_pkg;

  // Widest index any rr_sel instance may use; slot indices are carried at this width.
  localparam int unsigned RR_SEL_MAX_IDX_W = 16;
  localparam int unsigned RR_SEL_SUM_W     = RR_SEL_MAX_IDX_W + 1;

  typedef struct packed {
    logic                        valid;
    logic [RR_SEL_MAX_IDX_W-1:0] idx;
  } rr_sel_slot_t;

  // (idx + 1) mod num_req, computed one bit wider so non-power-of-2 counts wrap correctly.
  function automatic logic [RR_SEL_MAX_IDX_W-1:0] rr_sel_mod_inc(
    input logic [RR_SEL_MAX_IDX_W-1:0] idx,
    input int unsigned                 num_req
  );
    logic [RR_SEL_SUM_W-1:0] sum;
    sum = {1'b0, idx} + RR_SEL_SUM_W'(1);
    if (sum >= RR_SEL_SUM_W'(num_req)) begin
      sum = sum - RR_SEL_SUM_W'(num_req);
    end
    return sum[RR_SEL_MAX_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_sel_rot_psel.sv
// Rotating priority select: first set request at or after start, modulo NUM_REQ.
module rot_psel #(
  parameter int unsigned NUM_REQ = 8,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk the ring from start; start < NUM_REQ so a single subtract wraps the sum.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, start} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel.sv
// Multi-grant round-robin selector with a registered fairness pointer.
// Define RR_SEL_LOCK_EN to add the lock port and a lock-owner register.
module rr_sel
  import rr_sel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned NUM_GNT = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req,
`ifdef RR_SEL_LOCK_EN
  input  logic [NUM_REQ-1:0]              lock,
`endif
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_GNT-1:0]              gnt_valid,
  output logic [NUM_GNT-1:0][IDX_W-1:0]   gnt_idx,
  output logic [IDX_W-1:0]                ptr
);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;

  logic [NUM_REQ-1:0] stg_req   [NUM_GNT];
  logic [IDX_W-1:0]   stg_start [NUM_GNT];
  logic [IDX_W-1:0]   stg_idx   [NUM_GNT];
  logic [NUM_GNT-1:0] stg_found;

  rr_sel_slot_t       slot [NUM_GNT];
  logic               chain;
  logic               hold;

`ifdef RR_SEL_LOCK_EN
  logic               own_valid_q;
  logic               own_valid_d;
  logic [IDX_W-1:0]   own_idx_q;
  logic [IDX_W-1:0]   own_idx_d;
`endif

  // Selector chain: each stage removes the previous winner and resumes just past it.
  for (genvar k = 0; k < NUM_GNT; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_req[k]   = req;
      assign stg_start[k] = ptr_q;
    end else begin : g_next
      assign stg_req[k]   = stg_req[k-1] &
                            ~(NUM_REQ'(stg_found[k-1]) << stg_idx[k-1]);
      assign stg_start[k] = IDX_W'(rr_sel_mod_inc(RR_SEL_MAX_IDX_W'(stg_idx[k-1]), NUM_REQ));
    end

    rot_psel #(
      .NUM_REQ (NUM_REQ)
    ) u_psel (
      .req   (stg_req[k]),
      .start (stg_start[k]),
      .found (stg_found[k]),
      .idx   (stg_idx[k])
    );
  end

  // Slot assembly, grant outputs and next pointer / owner state.
  always_comb begin
    ptr_d     = ptr_q;
    gnt       = '0;
    gnt_valid = '0;
    gnt_idx   = '0;
    chain     = 1'b1;
    hold      = 1'b0;
    for (int unsigned k = 0; k < NUM_GNT; k++) begin
      slot[k] = '0;
    end
`ifdef RR_SEL_LOCK_EN
    own_valid_d = own_valid_q;
    own_idx_d   = own_idx_q;
`endif

    if (en && !reset) begin
`ifdef RR_SEL_LOCK_EN
      hold = own_valid_q && req[own_idx_q] && lock[own_idx_q];
      if (!hold) begin
        own_valid_d = 1'b0;
      end
`endif
      if (hold) begin
`ifdef RR_SEL_LOCK_EN
        slot[0].valid = 1'b1;
        slot[0].idx   = RR_SEL_MAX_IDX_W'(own_idx_q);
`endif
      end else begin
        for (int unsigned k = 0; k < NUM_GNT; k++) begin
          slot[k].valid = chain && stg_found[k];
          slot[k].idx   = RR_SEL_MAX_IDX_W'(stg_idx[k]);
          chain         = slot[k].valid;
        end
      end

      for (int unsigned k = 0; k < NUM_GNT; k++) begin
        if (slot[k].valid) begin
          gnt          = gnt | (NUM_REQ'(1) << IDX_W'(slot[k].idx));
          gnt_valid[k] = 1'b1;
          gnt_idx[k]   = IDX_W'(slot[k].idx);
          if (!hold) begin
            ptr_d = IDX_W'(rr_sel_mod_inc(slot[k].idx, NUM_REQ));
          end
        end
      end

`ifdef RR_SEL_LOCK_EN
      // A locked winner in slot 0 takes ownership from the next cycle.
      if (!hold && slot[0].valid && lock[IDX_W'(slot[0].idx)]) begin
        own_valid_d = 1'b1;
        own_idx_d   = IDX_W'(slot[0].idx);
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef RR_SEL_LOCK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      own_valid_q <= 1'b0;
      own_idx_q   <= '0;
    end else begin
      own_valid_q <= own_valid_d;
      own_idx_q   <= own_idx_d;
    end
  end
`endif

  assign ptr = ptr_q;

endmodule

// File: tb/tb_rr_sel.sv
// Directed table-driven bench for rr_sel with NUM_REQ=8, NUM_GNT=2.
module tb_rr_sel;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] lock;
    logic [7:0] exp_gnt;
    logic [1:0] exp_valid;
    logic [2:0] exp_i0;
    logic [2:0] exp_i1;
    logic [2:0] exp_ptr;
  } vec_t;

  logic            clock;
  logic            reset;
  logic            en;
  logic [7:0]      req;
  logic [7:0]      lock;
  logic [7:0]      gnt;
  logic [1:0]      gnt_valid;
  logic [1:0][2:0] gnt_idx;
  logic [2:0]      ptr;

  int total;
  int bad;
  vec_t vecs[$];

  rr_sel #(
    .NUM_REQ (8),
    .NUM_GNT (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req       (req),
`ifdef RR_SEL_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr       (ptr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                              input logic [7:0] l, input logic [7:0] g,
                              input logic [1:0] v, input logic [2:0] i0,
                              input logic [2:0] i1, input logic [2:0] p);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.lock = l; t.exp_gnt = g;
    t.exp_valid = v; t.exp_i0 = i0; t.exp_i1 = i1; t.exp_ptr = p;
    return t;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    en    = 1'b0;
    req   = '0;
    lock  = '0;

    // rst en req lock | gnt valid i0 i1 ptr(before edge)
    vecs.push_back(mk(1, 1, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h03, 2'b11, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h0C, 2'b11, 2, 3, 2));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h30, 2'b11, 4, 5, 4));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'hC0, 2'b11, 6, 7, 6));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h03, 2'b11, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h20, 8'h00, 8'h20, 2'b01, 5, 0, 2));
    vecs.push_back(mk(0, 1, 8'h81, 8'h00, 8'h81, 2'b11, 7, 0, 6));
    vecs.push_back(mk(0, 1, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'h80, 8'h00, 8'h80, 2'b01, 7, 0, 1));
    vecs.push_back(mk(0, 1, 8'h10, 8'h00, 8'h10, 2'b01, 4, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 5));
    vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 5));
    vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h60, 2'b11, 5, 6, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h81, 2'b11, 7, 0, 7));
    vecs.push_back(mk(0, 1, 8'h05, 8'h00, 8'h05, 2'b11, 2, 0, 1));
    vecs.push_back(mk(0, 1, 8'h02, 8'h00, 8'h02, 2'b01, 1, 0, 1));
    // reset in mid-operation, then restart from index 0
    vecs.push_back(mk(1, 1, 8'hFF, 8'h00, 8'h00, 2'b00, 0, 0, 2));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h03, 2'b11, 0, 1, 0));
`ifdef RR_SEL_LOCK_EN
    vecs.push_back(mk(0, 1, 8'h04, 8'h00, 8'h04, 2'b01, 2, 0, 2));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h08, 8'h18, 2'b11, 3, 4, 3));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h08, 8'h08, 2'b01, 3, 0, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h08, 8'h08, 2'b01, 3, 0, 5));
    vecs.push_back(mk(0, 0, 8'hFF, 8'h08, 8'h00, 2'b00, 0, 0, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h08, 8'h08, 2'b01, 3, 0, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h60, 2'b11, 5, 6, 5));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h00, 8'h81, 2'b11, 7, 0, 7));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h02, 8'h06, 2'b11, 1, 2, 1));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h02, 8'h02, 2'b01, 1, 0, 3));
    vecs.push_back(mk(0, 1, 8'hFD, 8'h02, 8'h18, 2'b11, 3, 4, 3));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h02, 8'h60, 2'b11, 5, 6, 5));
    // reset while an owner is held
    vecs.push_back(mk(0, 1, 8'hFF, 8'h80, 8'h81, 2'b11, 7, 0, 7));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h80, 8'h80, 2'b01, 7, 0, 1));
    vecs.push_back(mk(1, 1, 8'hFF, 8'h80, 8'h00, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'hFF, 8'h80, 8'h03, 2'b11, 0, 1, 0));
`endif

    foreach (vecs[n]) begin
      @(negedge clock);
      reset = vecs[n].rst;
      en    = vecs[n].en;
      req   = vecs[n].req;
      lock  = vecs[n].lock;
      #1;
      chk("gnt",       n, int'(gnt),        int'(vecs[n].exp_gnt));
      chk("gnt_valid", n, int'(gnt_valid),  int'(vecs[n].exp_valid));
      chk("gnt_idx0",  n, int'(gnt_idx[0]), int'(vecs[n].exp_i0));
      chk("gnt_idx1",  n, int'(gnt_idx[1]), int'(vecs[n].exp_i1));
      // ptr is undefined before the first reset edge, so skip it on reset rows
      if (!vecs[n].rst) begin
        chk("ptr", n, int'(ptr), int'(vecs[n].exp_ptr));
      end
    end

    // pointer after the last edge: 0,1 granted so it should sit at 2
    @(negedge clock);
    en = 1'b0;
    #1;
    chk("ptr_final", vecs.size(), int'(ptr), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
